// File: rtl/dcache_pkg.sv
// dcache_pkg: shared load/store encodings, FSM states and block geometry for dcache
package dcache_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
endpackage

// File: rtl/dcache_align.sv
// dcache_align: word -> ldata (byte/half/word extract + sign/zero extend); word+wdata -> merged (store byte lanes)
module dcache_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offs,
  input  logic [2:0]  funct3,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] be;
  logic [31:0] src;
  always_comb begin
    b = word[{offs, 3'b000} +: 8];
    h = offs[1] ? word[31:16] : word[15:0];
    ldata = funct3 == LB ? {{24{b[7]}}, b} : funct3 == LBU ? {24'b0, b} :
            funct3 == LH ? {{16{h[15]}}, h} : funct3 == LHU ? {16'b0, h} :
            funct3 == LW ? word : '0;
    be = size == SB ? 4'b0001 << offs : size == SH ? (offs[1] ? 4'b1100 : 4'b0011) :
         size == SW ? 4'b1111 : 4'b0000;
    src = size == SB ? {4{wdata[7:0]}} : size == SH ? {2{wdata[15:0]}} : wdata;
  end
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? src[8*i +: 8] : word[8*i +: 8];
  end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back/write-allocate cache; CPU port read/write/address/writedata -> readdata/busywait, 128-bit block memory port mem_*
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [3:0]                   read,
  input  logic [2:0]                   write,
  input  logic [31:0]                  address,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic                         busywait,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [31-OFF_W:0]            mem_address,
  output logic [8*BLOCK_BYTES-1:0]     mem_writedata,
  input  logic [8*BLOCK_BYTES-1:0]     mem_readdata,
  input  logic                         mem_busywait
);
  localparam int IDX = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX;
  state_t state, next;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [8*BLOCK_BYTES-1:0] data [LINES];
  logic [TAG_W-1:0] tag;
  logic [IDX-1:0] idx;
  logic [1:0] wsel;
  logic rd, wr, req, hit;
  logic [8*BLOCK_BYTES-1:0] line;
  logic [31:0] word, ldata, merged;
  assign tag = address[31:OFF_W+IDX];
  assign idx = address[OFF_W+IDX-1:OFF_W];
  assign wsel = address[3:2];
  assign rd = read[3];
  assign wr = write[2] & ~read[3];
  assign req = read[3] | write[2];
  assign line = data[idx];
  assign word = line[{wsel, 5'b00000} +: 32];
  assign hit = valid[idx] && tags[idx] == tag;
  assign mem_writedata = line;
  dcache_align u_align (
    .word(word),
    .offs(address[1:0]),
    .funct3(read[2:0]),
    .size(write[1:0]),
    .wdata(writedata),
    .ldata(ldata),
    .merged(merged)
  );
  always_comb begin
    next = state;
    busywait = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = address[31:OFF_W];
    readdata = '0;
    case (state)
      IDLE: begin
        busywait = req & ~hit;
        readdata = rd & hit ? ldata : '0;
        next = req & ~hit ? (dirty[idx] ? WRITEBACK : ALLOCATE) : IDLE;
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_address = {tags[idx], idx};
        next = mem_busywait ? WRITEBACK : ALLOCATE;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        next = mem_busywait ? ALLOCATE : UPDATE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= next;
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (state == IDLE && wr && hit) dirty[idx] <= 1'b1;
    end
  end
  // tag/data arrays need no reset: an entry is only observed once valid is set
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      data[idx] <= mem_readdata;
      tags[idx] <= tag;
    end else if (state == IDLE && wr && hit) data[idx][{wsel, 5'b00000} +: 32] <= merged;
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed and randomized checks of dcache against a flat byte-memory reference model
module tb_dcache;
  import dcache_pkg::*;
  logic clock = 0;
  logic reset = 1;
  logic [3:0] read = 0;
  logic [2:0] write = 0;
  logic [31:0] address = 0, writedata = 0;
  logic [31:0] readdata;
  logic busywait, mem_read, mem_write;
  logic [27:0] mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = 0;
  logic mem_busywait = 0;
  int errors = 0;
  int checks = 0;
  logic [7:0] arch [1024];
  logic [7:0] back [1024];
  int res_tag [8];
  bit res_dirty [8];
  logic [27:0] wb_addr;
  logic [127:0] wb_data;
  logic [2:0] f3s [5] = '{LB, LH, LW, LBU, LHU};

  dcache #(.LINES(8)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk_of(input bit use_arch, input int b);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = use_arch ? arch[16*b+k] : back[16*b+k];
    return v;
  endfunction

  function automatic logic [31:0] ld_exp(input logic [2:0] f3, input int a);
    int bv, hv, ha, wa;
    ha = a & ~1;
    wa = a & ~3;
    bv = int'(arch[a]);
    hv = int'(arch[ha]) + 256 * int'(arch[ha+1]);
    case (f3)
      LB: return 32'(bv >= 128 ? bv - 256 : bv);
      LBU: return 32'(bv);
      LH: return 32'(hv >= 32768 ? hv - 65536 : hv);
      LHU: return 32'(hv);
      default: return {arch[wa+3], arch[wa+2], arch[wa+1], arch[wa]};
    endcase
  endfunction

  task automatic st_model(input logic [1:0] sz, input int a, input logic [31:0] wd);
    if (sz == SB) arch[a] = wd[7:0];
    else if (sz == SH) begin
      arch[a & ~1] = wd[7:0];
      arch[(a & ~1) + 1] = wd[15:8];
    end else if (sz == SW) for (int k = 0; k < 4; k++) arch[(a & ~3) + k] = wd[8*k +: 8];
  endtask

  task automatic cpu(input bit rd, input logic [2:0] f3, input bit wr, input logic [1:0] sz,
                     input int a, input logic [31:0] wd, input int lat, output logic [31:0] rdata);
    int blk, idx, tg, cyc, cnt, last_done, exp_cyc, victim;
    bit hit;
    logic [27:0] held;
    logic [31:0] exp_rd;
    blk = a / 16;
    idx = blk % 8;
    tg = blk / 8;
    hit = res_tag[idx] == tg;
    victim = res_tag[idx] * 8 + idx;
    exp_cyc = hit ? 0 : res_dirty[idx] ? 2 * lat + 4 : lat + 3;
    exp_rd = rd ? ld_exp(f3, a) : 32'h0;
    cyc = 0;
    cnt = 0;
    last_done = 0;
    held = 0;
    @(negedge clock);
    read = {rd, f3};
    write = {wr, sz};
    address = a;
    writedata = wd;
    #1;
    while (busywait === 1'b1 && cyc < 200) begin
      if (cyc == 0) chk("miss_readdata_zero", readdata, 0);
      chk("mem_exclusive", mem_read & mem_write, 0);
      if (last_done == 1) chk("after_writeback", {mem_read, mem_write}, 2'b10);
      if (last_done == 2) chk("after_allocate", {mem_read, mem_write}, 2'b00);
      last_done = 0;
      if (mem_read || mem_write) begin
        if (cnt == 0) held = mem_address;
        else chk("mem_addr_stable", mem_address, held);
        if (cnt < lat) begin
          mem_busywait = 1;
          cnt++;
        end else begin
          mem_busywait = 0;
          cnt = 0;
          if (mem_write) begin
            wb_addr = mem_address;
            wb_data = mem_writedata;
            chk("wb_addr", mem_address, 28'(victim));
            chk("wb_data", mem_writedata, blk_of(1, victim));
            for (int k = 0; k < 16; k++) back[16*victim+k] = mem_writedata[8*k +: 8];
            last_done = 1;
          end else begin
            chk("alloc_addr", mem_address, 28'(blk));
            mem_readdata = blk_of(0, blk);
            last_done = 2;
          end
        end
      end
      cyc++;
      @(negedge clock);
      #1;
    end
    mem_busywait = 0;
    chk("stall_cycles", 32'(cyc), 32'(exp_cyc));
    chk("readdata", readdata, exp_rd);
    rdata = readdata;
    if (!hit) begin
      res_tag[idx] = tg;
      res_dirty[idx] = 0;
    end
    if (wr && !rd) begin
      res_dirty[idx] = 1;
      st_model(sz, a, wd);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      res_tag[i] = -1;
      res_dirty[i] = 0;
    end
    for (int i = 0; i < 1024; i++) arch[i] = back[i];
  endtask

  initial begin
    logic [31:0] r;
    int w;
    for (int i = 0; i < 1024; i++) back[i] = 8'($urandom);
    {back[16*4+3], back[16*4+2], back[16*4+1], back[16*4]} = 32'h44332211;
    {back[16*4+7], back[16*4+6], back[16*4+5], back[16*4+4]} = 32'hDEADBEEF;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk("rst_busywait", busywait, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_readdata", readdata, 0);
    cpu(1, LW, 0, SB, 'h40, 0, 2, r);
    chk("plan_lw40_miss", r, 32'h44332211);
    cpu(1, LW, 0, SB, 'h40, 0, 0, r);
    chk("plan_lw40_hit", r, 32'h44332211);
    cpu(1, LB, 0, SB, 'h41, 0, 0, r);
    chk("plan_lb41", r, 32'h00000022);
    cpu(1, LB, 0, SB, 'h43, 0, 0, r);
    chk("plan_lb43", r, 32'h00000044);
    cpu(0, LB, 1, SB, 'h42, 32'h80, 0, r);
    cpu(1, LB, 0, SB, 'h42, 0, 0, r);
    chk("plan_lb42", r, 32'hFFFFFF80);
    cpu(1, LBU, 0, SB, 'h42, 0, 0, r);
    chk("plan_lbu42", r, 32'h00000080);
    cpu(1, LHU, 0, SB, 'h42, 0, 0, r);
    chk("plan_lhu42", r, 32'h00004480);
    cpu(0, LB, 1, SW, 'h44, 32'hCAFEBABE, 0, r);
    cpu(1, LW, 0, SB, 'hC4, 0, 1, r);
    chk("plan_wb_addr", wb_addr, 28'h4);
    chk("plan_wb_word1", wb_data[63:32], 32'hCAFEBABE);
    cpu(1, LW, 0, SB, 'h100, 0, 5, r);
    cpu(0, LB, 1, SW, 'h140, 32'h5555AAAA, 1, r);
    @(negedge clock);
    read = {1'b1, LW};
    write = 0;
    address = 'h40;
    mem_busywait = 1;
    w = 0;
    do begin
      @(negedge clock);
      #1;
      w++;
    end while (!mem_write && w < 20);
    chk("rst_wb_reached", mem_write, 1);
    reset = 1;
    read = 0;
    @(negedge clock);
    #1;
    chk("rst_mid_wb_mem_write", mem_write, 0);
    chk("rst_mid_wb_busywait", busywait, 0);
    chk("rst_mid_wb_mem_read", mem_read, 0);
    reset = 0;
    mem_busywait = 0;
    model_reset();
    cpu(1, LW, 0, SB, 'h40, 0, 0, r);
    chk("rst_lw40_refetch", r, 32'h44802211);
    cpu(1, LW, 1, SW, 'h40, 32'h12345678, 0, r);
    chk("both_readdata", r, 32'h44802211);
    cpu(1, LW, 0, SB, 'h40, 0, 0, r);
    chk("both_line_unchanged", r, 32'h44802211);
    for (int n = 0; n < 400; n++) begin
      int a, op, lat;
      a = $urandom_range(0, 1023);
      op = $urandom_range(0, 9);
      lat = $urandom_range(0, 3);
      if (op < 5) cpu(1, f3s[$urandom_range(0, 4)], 0, SB, a, 0, lat, r);
      else if (op < 9) cpu(0, LB, 1, 2'($urandom_range(0, 2)), a, $urandom, lat, r);
      else cpu(1, f3s[$urandom_range(0, 4)], 1, 2'($urandom_range(0, 2)), a, $urandom, lat, r);
    end
    @(negedge clock);
    read = 0;
    write = 0;
    #1;
    chk("idle_busywait", busywait, 0);
    chk("idle_readdata", readdata, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
